// File: rtl/fib_dispatch.sv
// Request dispatcher for the Fibonacci kernel: launches one job per request,
// enforces a WAIT timeout and buffers {err, cycles, result} responses in a FIFO.
module fib_dispatch #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_n,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        k_r_enable,
    output logic        k_control_arr,
    output logic [5:0]  k_init_n,
    output logic [31:0] k_init_a,
    output logic [31:0] k_init_b,
    input  logic        k_w_enable,
    input  logic [31:0] k_result,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_err,
    output logic [15:0] resp_cycles,
    output logic [31:0] resp_result,
    output logic        busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [16:0]   TIMEOUT_C = 17'(TIMEOUT);
    localparam logic [15:0]   TIMEOUT16 = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

    typedef struct packed {
        logic        err;
        logic [15:0] cycles;
        logic [31:0] result;
    } resp_t;

    state_e      state_q, state_d;
    logic [15:0] cyc_q, cyc_d;
    logic        r_enable_q, r_enable_d;
    logic        busy_q, busy_d;
    logic [5:0]  init_n_q, init_n_d;
    logic [31:0] init_a_q, init_a_d;
    logic [31:0] init_b_q, init_b_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    resp_t       mem_q [DEPTH];
    resp_t       mem_d [DEPTH];

    logic        accept, push, pop;
    resp_t       push_data;
    logic [16:0] cyc_inc;
    logic [15:0] cyc_sat;

    assign req_ready = (state_q == IDLE) && (count_q < DEPTH_C);
    assign accept    = req_valid && req_ready;
    assign resp_valid = (count_q != '0);
    assign pop       = resp_valid && resp_ready;
    assign cyc_inc   = {1'b0, cyc_q} + 17'd1;
    assign cyc_sat   = cyc_inc[16] ? 16'hFFFF : cyc_inc[15:0];

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        r_enable_d = 1'b0;
        init_n_d   = init_n_q;
        init_a_d   = init_a_q;
        init_b_d   = init_b_q;
        push       = 1'b0;
        push_data  = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    r_enable_d = 1'b1;
                    init_n_d   = req_n;
                    init_a_d   = req_a;
                    init_b_d   = req_b;
                end
            end
            START: begin
                cyc_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion wins over timeout when both land in the same cycle.
                if (k_w_enable) begin
                    push      = 1'b1;
                    push_data = '{err: 1'b0, cycles: cyc_sat, result: k_result};
                    state_d   = IDLE;
                end else if (cyc_inc == TIMEOUT_C) begin
                    push      = 1'b1;
                    push_data = '{err: 1'b1, cycles: TIMEOUT16, result: 32'd0};
                    state_d   = IDLE;
                end else begin
                    cyc_d = cyc_sat;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Slot is reserved at accept time, so a push never finds the buffer full.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            r_enable_q <= 1'b0;
            busy_q     <= 1'b0;
            init_n_q   <= '0;
            init_a_q   <= '0;
            init_b_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            r_enable_q <= r_enable_d;
            busy_q     <= busy_d;
            init_n_q   <= init_n_d;
            init_a_q   <= init_a_d;
            init_b_q   <= init_b_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign k_r_enable    = r_enable_q;
    assign k_control_arr = 1'b0;
    assign k_init_n      = init_n_q;
    assign k_init_a      = init_a_q;
    assign k_init_b      = init_b_q;
    assign busy          = busy_q;
    assign resp_err      = mem_q[rd_ptr_q].err;
    assign resp_cycles   = mem_q[rd_ptr_q].cycles;
    assign resp_result   = mem_q[rd_ptr_q].result;

endmodule

// File: tb/tb_fib_dispatch.sv
// Bench for fib_dispatch: stub kernel with programmable latency, table vectors,
// hand sequences for full-buffer and mid-job reset, then randomized traffic.
module tb_fib_dispatch;
    localparam int TO    = 12;
    localparam int DEPTH = 2;

    logic        clk, rst_n;
    logic        req_valid, req_ready;
    logic [5:0]  req_n;
    logic [31:0] req_a, req_b;
    logic        k_r_enable, k_control_arr;
    logic [5:0]  k_init_n;
    logic [31:0] k_init_a, k_init_b;
    logic        k_w_enable;
    logic [31:0] k_result;
    logic        resp_valid, resp_ready, resp_err;
    logic [15:0] resp_cycles;
    logic [31:0] resp_result;
    logic        busy;

    fib_dispatch #(.TIMEOUT(TO), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_n(req_n), .req_a(req_a), .req_b(req_b),
        .k_r_enable(k_r_enable), .k_control_arr(k_control_arr),
        .k_init_n(k_init_n), .k_init_a(k_init_a), .k_init_b(k_init_b),
        .k_w_enable(k_w_enable), .k_result(k_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_err(resp_err), .resp_cycles(resp_cycles), .resp_result(resp_result),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [15:0] cyc;
        logic [31:0] res;
    } exp_t;

    typedef struct {
        logic [5:0]  n;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        exp_t        e;
    } vec_t;

    int   vectors = 0, miscompares = 0;
    int   accepts = 0, rpulse = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: a job with latency L completes at WAIT cycle L unless the
    // timeout (cycle TO) comes first; lat==0 means the kernel never finishes.
    function automatic exp_t model(input logic [5:0] n, input logic [31:0] a,
                                   input logic [31:0] b, input int lat);
        if (lat >= 1 && lat <= TO) return '{1'b0, 16'(lat), a + b + 32'(n)};
        return '{1'b1, 16'(TO), 32'd0};
    endfunction

    // Stub kernel: w_enable starts high (stale) and is cleared by r_enable.
    int   next_lat = 0;
    int   stub_lat = 0, stub_t = 0;
    logic stub_wen = 1'b1;
    always @(posedge clk) begin
        if (k_r_enable) begin
            stub_lat <= next_lat;
            stub_t   <= 1;
            stub_wen <= (next_lat == 1);
        end else if (stub_lat != 0 && stub_t < stub_lat) begin
            stub_t   <= stub_t + 1;
            stub_wen <= (stub_t + 1 >= stub_lat);
        end
    end
    assign k_w_enable = stub_wen;
    assign k_result   = stub_wen ? (k_init_a + k_init_b + {26'd0, k_init_n}) : 32'hBAD0_BAD0;

    // Response scoreboard and start-pulse width monitor.
    logic prev_ren = 1'b0;
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            check("resp_expected", exp_q.size() == 0, 1'b0);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_err", resp_err, e.err);
                check("resp_cycles", resp_cycles, e.cyc);
                check("resp_result", resp_result, e.res);
            end
        end
        if (k_r_enable) begin
            rpulse++;
            check("r_enable_single", prev_ren, 1'b0);
        end
        prev_ren = k_r_enable;
    end

    task automatic send(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input exp_t e);
        logic fire, ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_n = n; req_a = a; req_b = b;
        next_lat = lat;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            fire = req_ready;
            @(posedge clk); #1;
            if (fire) begin ok = 1'b1; break; end
        end
        req_valid = 1'b0;
        check("req_accepted", ok, 1'b1);
        if (ok) begin
            accepts++;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("wait_idle", busy, 1'b0);
    endtask

    vec_t tbl[7];
    logic done = 1'b0;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{6'd0,  32'd5,        32'd7,   5,  '{1'b0, 16'd5,  32'd12}};
        tbl[1] = '{6'd3,  32'd100,      32'd1,   10, '{1'b0, 16'd10, 32'd104}};
        tbl[2] = '{6'd1,  32'd0,        32'd0,   14, '{1'b1, 16'd12, 32'd0}};
        tbl[3] = '{6'd2,  32'd1,        32'd2,   3,  '{1'b0, 16'd3,  32'd5}};
        tbl[4] = '{6'd63, 32'hFFFFFFFF, 32'd1,   1,  '{1'b0, 16'd1,  32'd63}};
        tbl[5] = '{6'd4,  32'd9,        32'd9,   12, '{1'b0, 16'd12, 32'd22}};
        tbl[6] = '{6'd5,  32'd0,        32'd0,   13, '{1'b1, 16'd12, 32'd0}};

        rst_n = 1'b0; req_valid = 1'b0; req_n = '0; req_a = '0; req_b = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_r_enable", k_r_enable, 1'b0);
        check("rst_init", {k_init_n, k_init_a, k_init_b}, '0);
        check("control_arr", k_control_arr, 1'b0);

        // Table vectors, one job at a time; stale w_enable precedes several starts.
        foreach (tbl[i]) begin
            int bc;
            send(tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].e);
            check("start_pulse", k_r_enable, 1'b1);
            check("init_latched", {k_init_n, k_init_a, k_init_b}, {tbl[i].n, tbl[i].a, tbl[i].b});
            bc = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (busy) bc++; else break;
            end
            check("busy_cycles", bc, int'(tbl[i].e.cyc) + 1);
            drain();
            repeat (4) @(posedge clk);
        end

        // Full buffer: two responses parked, third request must wait.
        @(posedge clk); #1 resp_ready = 1'b0;
        send(6'd1, 32'd10, 32'd20, 2, model(6'd1, 32'd10, 32'd20, 2));
        send(6'd2, 32'd30, 32'd40, 4, model(6'd2, 32'd30, 32'd40, 4));
        wait_idle();
        fork
            send(6'd3, 32'd50, 32'd60, 2, model(6'd3, 32'd50, 32'd60, 2));
        join_none
        repeat (5) @(negedge clk);
        check("full_req_ready", req_ready, 1'b0);
        check("full_busy", busy, 1'b0);
        check("full_resp_valid", resp_valid, 1'b1);
        @(posedge clk); #1 resp_ready = 1'b1;
        wait fork;
        drain();

        // Reset mid-WAIT with one entry buffered.
        @(posedge clk); #1 resp_ready = 1'b0;
        send(6'd7, 32'd1, 32'd1, 2, model(6'd7, 32'd1, 32'd1, 2));
        wait_idle();
        send(6'd8, 32'd2, 32'd2, 0, model(6'd8, 32'd2, 32'd2, 0));
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_resp_valid", resp_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", req_ready, 1'b1);
        @(posedge clk); #1 resp_ready = 1'b1;
        send(6'd9, 32'd3, 32'd4, 4, model(6'd9, 32'd3, 32'd4, 4));
        drain();

        // Randomized traffic with random consumer back-pressure.
        fork
            begin
                for (int j = 0; j < 40; j++) begin
                    logic [5:0]  n;
                    logic [31:0] a, b;
                    int          lat;
                    n   = 6'($urandom);
                    a   = $urandom;
                    b   = $urandom;
                    lat = $urandom_range(0, 16);
                    send(n, a, b, lat, model(n, a, b, lat));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    resp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk); #1 resp_ready = 1'b1;
        drain();

        check("start_pulses", rpulse, accepts);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
